// File: rtl/rf_arb_pkg.sv
// Shared widths, the queued-write record and the address range check used by
// the register-file write arbiter and its load FIFO.
package rf_arb_pkg;

  localparam int AW   = 4;
  localparam int DW   = 32;
  localparam int NREG = 15;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          kill;
  } rf_wr_t;

  function automatic logic addr_in_range(input logic [AW-1:0] a);
    return a < AW'(NREG);
  endfunction

endpackage

// File: rtl/rf_wr_fifo.sv
// Load-result FIFO with per-entry kill bits and a parallel view of all entries,
// so the arbiter can squash stale loads and build the busy mask.
module rf_wr_fifo
  import rf_arb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic [AW-1:0]            push_addr_i,
  input  logic [DW-1:0]            push_data_i,
  input  logic                     push_kill_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  input  logic                     kill_en_i,
  input  logic [AW-1:0]            kill_addr_i,
  output logic [AW-1:0]            head_addr_o,
  output logic [DW-1:0]            head_data_o,
  output logic                     head_kill_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic [DEPTH-1:0]         live_o,
  output logic [DEPTH*AW-1:0]      addr_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  rf_wr_t        ent_q [DEPTH];
  logic [PW-1:0] rd_q, wr_q;
  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else if (flush_i) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (kill_en_i && ent_q[i].addr == kill_addr_i) ent_q[i].kill <= 1'b1;
      end
      // The incoming entry's kill already accounts for a same-cycle writeback.
      if (push_i) begin
        ent_q[wr_q] <= '{addr: push_addr_i, data: push_data_i, kill: push_kill_i};
        wr_q        <= wr_q + PW'(1);
      end
      if (pop_i) rd_q <= rd_q + PW'(1);
      cnt_q <= cnt_q + CW'(push_i) - CW'(pop_i);
    end
  end

  always_comb begin
    live_o = '0;
    addr_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      logic [PW-1:0] off;
      off = PW'(i) - rd_q;
      live_o[i] = ({1'b0, off} < cnt_q) && !ent_q[i].kill;
      addr_o[i*AW +: AW] = ent_q[i].addr;
    end
  end

  assign head_addr_o = ent_q[rd_q].addr;
  assign head_data_o = ent_q[rd_q].data;
  assign head_kill_o = ent_q[rd_q].kill;
  assign count_o     = cnt_q;

endmodule

// File: rtl/rf_write_arbiter.sv
// Shares the register-file write port between writeback (priority, no
// backpressure) and the queued load unit, keeping per-register program order.
module rf_write_arbiter
  import rf_arb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wb_valid,
  input  logic [AW-1:0]            wb_addr,
  input  logic [DW-1:0]            wb_data,
  input  logic                     mem_valid,
  output logic                     mem_ready,
  input  logic [AW-1:0]            mem_addr,
  input  logic [DW-1:0]            mem_data,
  input  logic                     flush,
  output logic                     we3,
  output logic [AW-1:0]            wa3,
  output logic [DW-1:0]            wd3,
  output logic [NREG-1:0]          busy,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     addr_err
);

  logic                we3_q, we3_d;
  logic [AW-1:0]       wa3_q, wa3_d;
  logic [DW-1:0]       wd3_q, wd3_d;
  logic                addr_err_q, addr_err_d;

  logic                push, pop, push_kill;
  logic [AW-1:0]       head_addr;
  logic [DW-1:0]       head_data;
  logic                head_kill;
  logic [DEPTH-1:0]    live;
  logic [DEPTH*AW-1:0] ent_addr;

  assign mem_ready = (fifo_count < ($clog2(DEPTH)+1)'(DEPTH)) && !flush;
  assign push      = mem_valid && mem_ready;
  assign pop       = !wb_valid && !flush && (fifo_count != '0);
  // Same-cycle load is older than writeback, so it must not land after it.
  assign push_kill = !addr_in_range(mem_addr) || (wb_valid && wb_addr == mem_addr);

  rf_wr_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (push),
    .push_addr_i (mem_addr),
    .push_data_i (mem_data),
    .push_kill_i (push_kill),
    .pop_i       (pop),
    .flush_i     (flush),
    .kill_en_i   (wb_valid),
    .kill_addr_i (wb_addr),
    .head_addr_o (head_addr),
    .head_data_o (head_data),
    .head_kill_o (head_kill),
    .count_o     (fifo_count),
    .live_o      (live),
    .addr_o      (ent_addr)
  );

  always_comb begin
    we3_d = 1'b0;
    wa3_d = '0;
    wd3_d = '0;
    if (wb_valid) begin
      we3_d = addr_in_range(wb_addr);
      wa3_d = wb_addr;
      wd3_d = wb_data;
    end else if (pop) begin
      we3_d = !head_kill;
      wa3_d = head_addr;
      wd3_d = head_data;
    end
    addr_err_d = (wb_valid && !addr_in_range(wb_addr)) ||
                 (push && !addr_in_range(mem_addr));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      we3_q      <= 1'b0;
      wa3_q      <= '0;
      wd3_q      <= '0;
      addr_err_q <= 1'b0;
    end else begin
      we3_q      <= we3_d;
      wa3_q      <= wa3_d;
      wd3_q      <= wd3_d;
      addr_err_q <= addr_err_d;
    end
  end

  always_comb begin
    busy = '0;
    for (int r = 0; r < NREG; r++) begin
      busy[r] = we3_q && (wa3_q == AW'(r));
      for (int i = 0; i < DEPTH; i++) begin
        if (live[i] && ent_addr[i*AW +: AW] == AW'(r)) busy[r] = 1'b1;
      end
    end
  end

  assign we3      = we3_q;
  assign wa3      = wa3_q;
  assign wd3      = wd3_q;
  assign addr_err = addr_err_q;

endmodule
